// File: rtl/mips_alu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package mips_alu_pkg;

  localparam int unsigned MULDIV_W        = 32;
  localparam int unsigned MUL_LATENCY_DEF = 3;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUL       = 3'd1,
    ST_DIV_SETUP = 3'd2,
    ST_DIV_ITER  = 3'd3,
    ST_DIV_FIX   = 3'd4
  } muldiv_state_t;

  // Two's-complement magnitude when en is set, value unchanged otherwise.
  function automatic logic [MULDIV_W-1:0] abs_if(input logic [MULDIV_W-1:0] v,
                                                 input logic                en);
    return (en && v[MULDIV_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mips_div_step.sv
// One combinational iteration of an unsigned restoring divider.
module mips_div_step
  import mips_alu_pkg::*;
#(
  parameter int unsigned W = MULDIV_W
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // Shift in the next dividend bit, trial-subtract, restore on a negative result.
  // Because rem_i < divisor_i always holds, a W+1 bit difference is enough:
  // non-negative results stay below 2^W and negative ones always set bit W.
  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (trial[W]) begin
      rem_o = shifted[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end else begin
      rem_o = trial[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: pipelined multiplier, iterative restoring
// divider, MTHI/MTLO writes and the busy/done handshake towards the pipeline.
module mips_muldiv_ctrl
  import mips_alu_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int unsigned DIV_BITS    = MULDIV_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                op_valid,
  input  logic [2:0]          op,
  input  logic [MULDIV_W-1:0] src_a,
  input  logic [MULDIV_W-1:0] src_b,
  output logic                op_ready,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero,
  output logic [MULDIV_W-1:0] hi,
  output logic [MULDIV_W-1:0] lo
);

  localparam int unsigned W      = MULDIV_W;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned STAGES = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;

  muldiv_op_t    op_e;
  muldiv_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]  opa_q, opb_q;
  logic          sgn_q;
  logic [W-1:0]  rem_q, quo_q, dvsr_q;
  logic [W-1:0]  rem_d, quo_d;
  logic          qneg_q, rneg_q;
  logic [W-1:0]  hi_q, lo_q;
  logic          busy_q, ready_q, done_q, dbz_q;

  logic [2*W-1:0] mul_a, mul_b, prod, mul_res;
  logic [2*W-1:0] pipe_q [STAGES];

  assign op_e = muldiv_op_t'(op);

  // Sign-extend only for MULT; the low 2W bits of the product are then correct
  // for both signed and unsigned operands.
  assign mul_a = {{W{sgn_q & opa_q[W-1]}}, opa_q};
  assign mul_b = {{W{sgn_q & opb_q[W-1]}}, opb_q};
  assign prod  = mul_a * mul_b;

  // Retiming stages behind the multiplier; operands are held while in MUL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < STAGES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= prod;
      for (int unsigned i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign mul_res = (MUL_LATENCY > 1) ? pipe_q[STAGES-1] : prod;

  mips_div_step #(
    .W (W)
  ) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  // Sequencer FSM with registered handshake outputs and the HI/LO pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            case (op_e)
              OP_MTHI: hi_q <= src_a;
              OP_MTLO: lo_q <= src_a;
              OP_MULT, OP_MULTU: begin
                opa_q   <= src_a;
                opb_q   <= src_b;
                sgn_q   <= (op_e == OP_MULT);
                cnt_q   <= CNT_W'(MUL_LATENCY - 1);
                state_q <= ST_MUL;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                if (src_b == '0) begin
                  done_q <= 1'b1;
                  dbz_q  <= 1'b1;
                end else begin
                  opa_q   <= src_a;
                  opb_q   <= src_b;
                  sgn_q   <= (op_e == OP_DIV);
                  state_q <= ST_DIV_SETUP;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cnt_q == '0) begin
            {hi_q, lo_q} <= mul_res;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DIV_SETUP: begin
          quo_q   <= abs_if(opa_q, sgn_q);
          dvsr_q  <= abs_if(opb_q, sgn_q);
          qneg_q  <= sgn_q & (opa_q[W-1] ^ opb_q[W-1]);
          rneg_q  <= sgn_q & opa_q[W-1];
          rem_q   <= '0;
          cnt_q   <= CNT_W'(DIV_BITS - 1);
          state_q <= ST_DIV_ITER;
        end
        ST_DIV_ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) state_q <= ST_DIV_FIX;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        ST_DIV_FIX: begin
          lo_q    <= qneg_q ? -quo_q : quo_q;
          hi_q    <= rneg_q ? -rem_q : rem_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign op_ready    = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Self-checking bench for mips_muldiv_ctrl against an arithmetic reference model.
module tb_mips_muldiv_ctrl;
  import mips_alu_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        op_ready, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mips_muldiv_ctrl #(
    .MUL_LATENCY (MUL_LAT),
    .DIV_BITS    (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_valid    (op_valid),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .op_ready    (op_ready),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model. kind: 0 = immediate write, 1 = multi-cycle, 2 = divide by zero.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int kind, output logic [31:0] nh, output logic [31:0] nl,
                          output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    nh = m_hi; nl = m_lo; lat = 0; kind = 0;
    case (o)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        nh = p[63:32]; nl = p[31:0]; kind = 1; lat = MUL_LAT;
      end
      OP_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        nh = p[63:32]; nl = p[31:0]; kind = 1; lat = MUL_LAT;
      end
      OP_DIV: begin
        if (b == 0) kind = 2;
        else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          nl = q[31:0]; nh = r[31:0]; kind = 1; lat = DIV_LAT;
        end
      end
      OP_DIVU: begin
        if (b == 0) kind = 2;
        else begin
          nl = a / b; nh = a % b; kind = 1; lat = DIV_LAT;
        end
      end
      OP_MTHI: nh = a;
      OP_MTLO: nl = a;
      default: ;
    endcase
  endtask

  // Waits for op_ready (bounded), presents the request and retires it at the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int unsigned guard = 0;
    @(negedge clk);
    while (!op_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: op_ready got %b expected 1", op_ready);
    end
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic exec_and_verify(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input string tag);
    int kind, lat, busy_cnt;
    logic [31:0] nh, nl;
    bit held, early;
    model_op(o, a, b, kind, nh, nl, lat);
    issue(o, a, b);
    if (kind == 0) begin
      @(negedge clk);
      checks++;
      if (hi !== nh || lo !== nl) begin
        errors++;
        $display("FAIL %s mt_write: hi/lo got %h/%h expected %h/%h", tag, hi, lo, nh, nl);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s mt_flags: busy/done got %b%b expected 00", tag, busy, done);
      end
    end else if (kind == 2) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || div_by_zero !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s dbz_flags: done/dbz/busy got %b%b%b expected 110",
                 tag, done, div_by_zero, busy);
      end
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL %s dbz_hold: hi/lo got %h/%h expected %h/%h", tag, hi, lo, m_hi, m_lo);
      end
    end else begin
      busy_cnt = 0; held = 1; early = 0;
      for (int unsigned k = 0; k < lat; k++) begin
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        if (done !== 1'b0) early = 1;
        if (hi !== m_hi || lo !== m_lo) held = 0;
      end
      checks++;
      if (busy_cnt != lat) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cnt, lat);
      end
      checks++;
      if (held !== 1'b1 || early !== 1'b0) begin
        errors++;
        $display("FAIL %s hold_during_busy: held/early got %b/%b expected 1/0", tag, held, early);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || div_by_zero !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s completion: done/dbz/busy/ready got %b%b%b%b expected 1001",
                 tag, done, div_by_zero, busy, op_ready);
      end
      checks++;
      if (hi !== nh || lo !== nl) begin
        errors++;
        $display("FAIL %s result: hi/lo got %h/%h expected %h/%h", tag, hi, lo, nh, nl);
      end
    end
    m_hi = nh; m_lo = nl;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; op_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h/%h expected 0/0", hi, lo);
    end
    checks++;
    if ({op_ready, busy, done, div_by_zero} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/done/dbz got %b%b%b%b expected 1000",
               op_ready, busy, done, div_by_zero);
    end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_directed();
    exec_and_verify(OP_MULT,  32'hFFFFFFFE, 32'd3,        "mult_neg2x3");
    exec_and_verify(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    exec_and_verify(OP_DIV,   32'hFFFFFFF9, 32'd2,        "div_m7_2");
    exec_and_verify(OP_DIVU,  32'd100,      32'd7,        "divu_100_7");
    exec_and_verify(OP_DIV,   32'h80000000, 32'hFFFFFFFF, "div_min_m1");
  endtask

  task automatic test_div_zero();
    exec_and_verify(OP_DIV,  32'h00001234, 32'h0, "div_zero");
    exec_and_verify(OP_DIVU, 32'hDEADBEEF, 32'h0, "divu_zero");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op_valid = 1'b1; op = OP_MTHI; src_a = 32'h12345678; src_b = '0;
    @(negedge clk);
    checks++;
    if (hi !== 32'h12345678 || busy !== 1'b0 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_mthi: hi/busy/ready got %h/%b/%b expected 12345678/0/1",
               hi, busy, op_ready);
    end
    op = OP_MTLO; src_a = 32'h9ABCDEF0;
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_mtlo: hi/lo/busy/done got %h/%h/%b/%b expected 12345678/9abcdef0/0/0",
               hi, lo, busy, done);
    end
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_request_during_busy();
    int kind, lat, ready_cnt;
    logic [31:0] dh, dl, mh, ml;
    bit held;
    model_op(OP_DIVU, 32'd1000, 32'd3, kind, dh, dl, lat);
    issue(OP_DIVU, 32'd1000, 32'd3);
    op_valid = 1'b1; op = OP_MULT; src_a = 32'hFFFF0000; src_b = 32'h00012345;
    ready_cnt = 0; held = 1;
    for (int unsigned k = 0; k < DIV_LAT; k++) begin
      @(negedge clk);
      if (op_ready !== 1'b0) ready_cnt++;
      if (hi !== m_hi || lo !== m_lo) held = 0;
    end
    checks++;
    if (ready_cnt != 0 || held !== 1'b1) begin
      errors++;
      $display("FAIL busy_req_block: ready_cycles/held got %0d/%b expected 0/1", ready_cnt, held);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || hi !== dh || lo !== dl || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_req_div: done/hi/lo/ready got %b/%h/%h/%b expected 1/%h/%h/1",
               done, hi, lo, op_ready, dh, dl);
    end
    m_hi = dh; m_lo = dl;
    model_op(OP_MULT, 32'hFFFF0000, 32'h00012345, kind, mh, ml, lat);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (MUL_LAT) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || hi !== dh || lo !== dl) begin
      errors++;
      $display("FAIL busy_req_mul_pending: busy/hi/lo got %b/%h/%h expected 1/%h/%h",
               busy, hi, lo, dh, dl);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || hi !== mh || lo !== ml) begin
      errors++;
      $display("FAIL busy_req_mul: done/hi/lo got %b/%h/%h expected 1/%h/%h",
               done, hi, lo, mh, ml);
    end
    m_hi = mh; m_lo = ml;
  endtask

  task automatic test_reset_mid_div();
    int unsigned done_seen = 0;
    exec_and_verify(OP_MTHI, $urandom() | 32'h1, 32'h0, "pre_reset_mthi");
    exec_and_verify(OP_MTLO, $urandom() | 32'h1, 32'h0, "pre_reset_mtlo");
    issue(OP_DIV, 32'h7654321F, 32'h00000123);
    repeat (11) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || op_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div: hi/lo/busy/ready/done got %h/%h/%b/%b/%b expected 0/0/0/1/0",
               hi, lo, busy, op_ready, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int unsigned k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: done cycles got %0d expected 0", done_seen);
    end
    m_hi = '0; m_lo = '0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] a, b;
    for (int unsigned n = 0; n < 40; n++) begin
      o = 3'($urandom_range(0, 5));
      a = pick_val();
      b = pick_val();
      exec_and_verify(o, a, b, $sformatf("rand%0d_op%0d", n, o));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_request_during_busy();
    test_random();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
